// File: rtl/std_fp_divmod_seq.sv
// Iterative fixed-point divide/modulo: restoring shift-subtract, one quotient bit per cycle,
// C-style signs. Define STD_FP_DIV_SAT_EN to saturate the quotient on overflow/divide-by-zero.
module std_fp_divmod_seq #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int SIGNED     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int ITER = WIDTH + FRAC_WIDTH;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
`ifdef STD_FP_DIV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_width_check
    $error("std_fp_divmod_seq: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] a);
    return ~a + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] v;
    if (SIGNED == 0) begin
      v = ALL_ONES;
    end else if (neg) begin
      v = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v;
  endfunction

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  rem_q;
  logic [ITER-1:0]   dvd_q;
  logic [WIDTH-1:0]  dvs_q;
  logic              neg_res_q;
  logic              neg_dvd_q;
  logic              dz_q;
  logic              ready_q;
  logic              done_q;
  logic [WIDTH-1:0]  quo_out_q;
  logic [WIDTH-1:0]  rem_out_q;
  logic              dz_out_q;
  logic              ovf_out_q;

  logic              l_neg_s;
  logic              r_neg_s;
  logic [WIDTH-1:0]  l_mag_s;
  logic [WIDTH-1:0]  r_mag_s;
  logic [WIDTH:0]    rem_shift_s;
  logic              ge_s;
  logic [WIDTH-1:0]  rem_d;
  logic [ITER-1:0]   dvd_d;
  logic              qf_hi_nz_s;
  logic [WIDTH-1:0]  q_wrap_s;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  rem_out_d;
  logic              ovf_d;

  // Operand magnitudes and signs presented for capture
  always_comb begin
    l_neg_s = (SIGNED != 0) && left[WIDTH-1];
    r_neg_s = (SIGNED != 0) && right[WIDTH-1];
    l_mag_s = l_neg_s ? negate(left) : left;
    r_mag_s = r_neg_s ? negate(right) : right;
  end

  // One restoring step: the dividend register fills with quotient bits from the LSB
  always_comb begin
    rem_shift_s = {rem_q, dvd_q[ITER-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_q});
    if (ge_s) begin
      rem_d = WIDTH'(rem_shift_s - {1'b0, dvs_q});
    end else begin
      rem_d = rem_shift_s[WIDTH-1:0];
    end
    dvd_d = {dvd_q[ITER-2:0], ge_s};
  end

  // Sign, overflow and saturation correction applied in FIX
  always_comb begin
    qf_hi_nz_s = |dvd_q[ITER-1:WIDTH];
    if (SIGNED == 0) begin
      ovf_d = qf_hi_nz_s;
    end else if (neg_res_q) begin
      ovf_d = qf_hi_nz_s | (dvd_q[WIDTH-1] & (|dvd_q[WIDTH-2:0]));
    end else begin
      ovf_d = qf_hi_nz_s | dvd_q[WIDTH-1];
    end
    q_wrap_s  = neg_res_q ? negate(dvd_q[WIDTH-1:0]) : dvd_q[WIDTH-1:0];
    quo_d     = (SAT_EN && ovf_d) ? sat_value(neg_res_q) : q_wrap_s;
    rem_out_d = neg_dvd_q ? negate(rem_q) : rem_q;
    if (dz_q) begin
      quo_d     = SAT_EN ? sat_value(neg_dvd_q) : ALL_ONES;
      rem_out_d = ZERO;
      ovf_d     = 1'b0;
    end else begin
      quo_d     = quo_d;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      rem_q     <= ZERO;
      dvd_q     <= {ITER{1'b0}};
      dvs_q     <= ZERO;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      dz_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      quo_out_q <= ZERO;
      rem_out_q <= ZERO;
      dz_out_q  <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (go) begin
            rem_q     <= ZERO;
            dvd_q     <= {l_mag_s, {FRAC_WIDTH{1'b0}}};
            dvs_q     <= r_mag_s;
            neg_dvd_q <= l_neg_s;
            neg_res_q <= l_neg_s ^ r_neg_s;
            dz_q      <= (right == ZERO);
            cnt_q     <= {CW{1'b0}};
            ready_q   <= 1'b0;
            state_q   <= (right == ZERO) ? S_FIX : S_RUN;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          quo_out_q <= quo_d;
          rem_out_q <= rem_out_d;
          dz_out_q  <= dz_q;
          ovf_out_q <= ovf_d;
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready         = ready_q;
  assign done          = done_q;
  assign out_quotient  = quo_out_q;
  assign out_remainder = rem_out_q;
  assign div_zero      = dz_out_q;
  assign overflow      = ovf_out_q;

endmodule

// File: tb/tb_std_fp_divmod_seq.sv
// Bench for std_fp_divmod_seq: one unsigned and one signed 8.4-bit instance, directed
// cases plus random operands against an integer-arithmetic reference model.
module tb_std_fp_divmod_seq;

  localparam int W      = 8;
  localparam int F      = 4;
  localparam int LAT    = W + F + 2;
  localparam int DZ_LAT = 2;
  localparam int TMO    = 40;
`ifdef STD_FP_DIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         go_u, go_s;
  logic [W-1:0] left_u, right_u, left_s, right_s;
  logic         ready_u, done_u, dz_u, ov_u;
  logic         ready_s, done_s, dz_s, ov_s;
  logic [W-1:0] q_u, r_u, q_s, r_s;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  std_fp_divmod_seq #(.WIDTH(W), .INT_WIDTH(W-F), .FRAC_WIDTH(F), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .go(go_u), .left(left_u), .right(right_u),
    .ready(ready_u), .done(done_u), .out_quotient(q_u), .out_remainder(r_u),
    .div_zero(dz_u), .overflow(ov_u));

  std_fp_divmod_seq #(.WIDTH(W), .INT_WIDTH(W-F), .FRAC_WIDTH(F), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .go(go_s), .left(left_s), .right(right_s),
    .ready(ready_s), .done(done_s), .out_quotient(q_s), .out_remainder(r_s),
    .div_zero(dz_s), .overflow(ov_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on real-valued magnitudes scaled by 2^F
  function automatic void ref_div(input bit sgn, input logic [W-1:0] l, input logic [W-1:0] r,
                                  output logic [W-1:0] q, output logic [W-1:0] rm,
                                  output logic dz, output logic ov);
    int li, ri, al, ar, qf, rr, qt, rt;
    bit neg;
    li = sgn ? int'($signed(l)) : int'(l);
    ri = sgn ? int'($signed(r)) : int'(r);
    dz = (ri == 0);
    ov = 1'b0;
    if (dz) begin
      rm = 8'h00;
      q  = 8'hFF;
      if (SAT && sgn) q = (li < 0) ? 8'h80 : 8'h7F;
    end else begin
      al  = (li < 0) ? -li : li;
      ar  = (ri < 0) ? -ri : ri;
      qf  = (al * (1 << F)) / ar;
      rr  = al * (1 << F) - qf * ar;
      neg = (li < 0) != (ri < 0);
      if (!sgn) ov = (qf > 255);
      else      ov = neg ? (qf > 128) : (qf > 127);
      qt = neg ? -qf : qf;
      q  = qt[W-1:0];
      if (ov && SAT) q = !sgn ? 8'hFF : (neg ? 8'h80 : 8'h7F);
      rt = (li < 0) ? -rr : rr;
      rm = rt[W-1:0];
    end
  endfunction

  task automatic drive(input bit s, input logic g, input logic [W-1:0] l, input logic [W-1:0] r);
    if (s) begin go_s = g; left_s = l; right_s = r; end
    else   begin go_u = g; left_u = l; right_u = r; end
  endtask

  task automatic wait_done(input bit s, output int cnt);
    cnt = 1;
    forever begin
      @(negedge clk);
      if ((s ? done_s : done_u) === 1'b1) break;
      if (cnt >= TMO) break;
      @(posedge clk);
      cnt++;
    end
  endtask

  task automatic check_result(input bit s, input string tag, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic edz, input logic eov);
    check({tag, ".quotient"},  s ? q_s  : q_u,  eq);
    check({tag, ".remainder"}, s ? r_s  : r_u,  er);
    check({tag, ".div_zero"},  s ? dz_s : dz_u, edz);
    check({tag, ".overflow"},  s ? ov_s : ov_u, eov);
  endtask

  task automatic run_op(input bit s, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov, input string tag);
    int cnt;
    @(negedge clk);
    check({tag, ".ready_before"}, s ? ready_s : ready_u, 1'b1);
    drive(s, 1'b1, l, r);
    @(posedge clk);
    #1 drive(s, 1'b0, 8'($urandom), 8'($urandom));
    wait_done(s, cnt);
    check({tag, ".latency"}, cnt, edz ? DZ_LAT : LAT);
    check({tag, ".ready_done"}, s ? ready_s : ready_u, 1'b1);
    check_result(s, tag, eq, er, edz, eov);
    @(negedge clk);
    check({tag, ".done_pulse"}, s ? done_s : done_u, 1'b0);
    check({tag, ".held_q"}, s ? q_s : q_u, eq);
  endtask

  task automatic run_rand(input bit s, input logic [W-1:0] l, input logic [W-1:0] r, input string tag);
    logic [W-1:0] eq, er;
    logic edz, eov;
    ref_div(s, l, r, eq, er, edz, eov);
    run_op(s, l, r, eq, er, edz, eov, tag);
  endtask

  initial begin
    int cnt;
    bit any_done;
    logic [W-1:0] a, b, eq, er;
    logic edz, eov;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("reset.ready_u", ready_u, 1'b1);
    check("reset.done_u",  done_u,  1'b0);
    check("reset.q_u",     q_u,     8'h00);
    check("reset.ready_s", ready_s, 1'b1);
    check("reset.ov_s",    ov_s,    1'b0);
    reset_n = 1'b1;

    run_op(1'b0, 8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0, "u_3div2");
    run_op(1'b0, 8'h10, 8'h30, 8'h05, 8'h10, 1'b0, 1'b0, "u_rem");
    run_op(1'b1, 8'hF0, 8'h30, 8'hFB, 8'hF0, 1'b0, 1'b0, "s_rem");
    run_op(1'b1, 8'hD0, 8'h20, 8'hE8, 8'h00, 1'b0, 1'b0, "s_neg");
    run_op(1'b0, 8'hF0, 8'h01, SAT ? 8'hFF : 8'h00, 8'h00, 1'b0, 1'b1, "u_ovf");
    run_op(1'b0, 8'h25, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, "u_dz");
    run_op(1'b1, 8'h80, 8'hF0, SAT ? 8'h7F : 8'h80, 8'h00, 1'b0, 1'b1, "s_ovf");

    // Reset mid-RUN, off the clock edge, discards the operation
    @(negedge clk);
    drive(1'b1, 1'b1, 8'hD0, 8'h20);
    @(posedge clk);
    #1 go_s = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst.ready", ready_s, 1'b1);
    check("midrst.done",  done_s,  1'b0);
    check("midrst.q",     q_s,     8'h00);
    check("midrst.r",     r_s,     8'h00);
    check("midrst.dz",    dz_s,    1'b0);
    check("midrst.ov",    ov_s,    1'b0);
    check("midrst.q_u",   q_u,     8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    any_done = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (done_s === 1'b1) any_done = 1'b1;
    end
    check("midrst.no_done", any_done, 1'b0);
    run_op(1'b1, 8'hD0, 8'h20, 8'hE8, 8'h00, 1'b0, 1'b0, "post_rst");

    // go held high: operands changed during RUN are ignored, DONE-cycle operands accepted
    a = 8'($urandom);
    b = 8'($urandom) | 8'h01;
    @(negedge clk);
    drive(1'b0, 1'b1, a, b);
    for (int k = 0; k < 4; k++) begin
      ref_div(1'b0, a, b, eq, er, edz, eov);
      @(posedge clk);
      #1 begin left_u = 8'($urandom); right_u = 8'($urandom); end
      wait_done(1'b0, cnt);
      check("b2b.latency", cnt, LAT);
      check_result(1'b0, "b2b", eq, er, edz, eov);
      a = 8'($urandom);
      b = 8'($urandom) | 8'h01;
      if (k < 3) begin
        left_u = a; right_u = b;
      end else begin
        go_u = 1'b0;
      end
    end

    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_rand(i[0], a, b, i[0] ? "rand_s" : "rand_u");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/std_fp_divmod_seq.md
# std_fp_divmod_seq

Iterative fixed-point divider, the next generation of the fixed-point pipelined divide primitive. It adds a signedness parameter, an asynchronous active-low reset, an explicit ready/go/done handshake with back-to-back issue, C-style remainder semantics, and divide-by-zero and overflow flags. It sits beside the other fixed-point arithmetic primitives and is instantiated by generated components wherever a `/` or `%` on fixed-point values is scheduled.

## Interface
- `WIDTH`, 32: total operand and result width in bits.
- `INT_WIDTH`, 16: integer bits; `INT_WIDTH + FRAC_WIDTH == WIDTH` is required, and an elaboration `$error` fires otherwise.
- `FRAC_WIDTH`, 16: fraction bits.
- `SIGNED`, 0: 0 selects unsigned operands; 1 selects two's-complement operands.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset; **one clock, reset asynchronous active-low**.
- `go`  in  1  start request; sampled only while `ready`=1.
- `left`  in  WIDTH  dividend; captured on an accepted `go`.
- `right`  in  WIDTH  divisor; captured on an accepted `go`.
- `ready`  out  1  can accept `go`; high in IDLE and DONE.
- `done`  out  1  single-cycle pulse; results are valid and held.
- `out_quotient`  out  WIDTH  fixed-point quotient.
- `out_remainder`  out  WIDTH  remainder.
- `div_zero`  out  1  the last operation had `right`==0.
- `overflow`  out  1  the last operation's quotient did not fit in WIDTH bits.

## Operation
- States:
  - IDLE: `ready`=1.
  - RUN: shift-subtract iterations.
  - FIX: sign and saturation correction, 1 cycle.
  - DONE: `done`=1 and `ready`=1, 1 cycle.
- Transitions:
  - IDLE --go--> RUN.
  - IDLE --go with `right`==0--> FIX; the iterations are skipped.
  - RUN --last iteration--> FIX.
  - FIX --> DONE.
  - DONE --go--> RUN or FIX, using the same rules as IDLE.
  - DONE --no go--> IDLE.
- Capture: the magnitudes |left| and |right| are captured as WIDTH-bit unsigned values. When SIGNED=0 the magnitude is the raw value. -2^(WIDTH-1) maps to 2^(WIDTH-1). The result sign and the dividend sign are latched.
- Arithmetic:
  - Full quotient Qf = floor((|L| << FRAC_WIDTH) / |R|), computed as WIDTH+FRAC_WIDTH bits, one bit per RUN cycle.
  - Remainder Rm = (|L| << FRAC_WIDTH) − Qf·|R|; it is always < |R| and fits in WIDTH bits.
- Result:
  - Quotient is negated if the operand signs differ, i.e. truncation toward zero.
  - Remainder is negated if the dividend is negative, so its sign follows the dividend.
- Overflow is set when the signed or unsigned result is not representable:
  - SIGNED=0: Qf ≥ 2^WIDTH.
  - SIGNED=1, positive result: Qf > 2^(WIDTH-1)−1.
  - SIGNED=1, negative result: Qf > 2^(WIDTH-1).
  - Without saturation the quotient is the low WIDTH bits of Qf with the sign then applied.
- Divide by zero: `div_zero`=1, `overflow`=0, remainder = 0. The quotient is all-ones, or the saturated value when saturation is enabled (see Configuration).
- `go` while in RUN or FIX is ignored. `left` and `right` may change freely after capture.

## Timing
- Let ITER = WIDTH + FRAC_WIDTH. The iteration counter is $clog2(ITER+1) bits wide.
- Accept edge = edge 0. RUN occupies edges 1..ITER. FIX is the cycle after edge ITER. `done` is high in the cycle after edge ITER+1.
- Latency from `go` to `done` is ITER+2 cycles; divide-by-zero latency is 2 cycles.
- Results and flags update on the edge that enters DONE. They hold until the edge that enters DONE for the next operation.
- Back-to-back: `go` during DONE is accepted with zero bubble, so throughput is one result per ITER+2 cycles.
- Reset (asynchronous, at any time, including mid-RUN) forces:
  - state IDLE;
  - `ready`=1;
  - `done`=0;
  - `out_quotient`=0, `out_remainder`=0;
  - `div_zero`=0, `overflow`=0;
  - counter = 0.
- The operation in progress is discarded and no `done` is produced for it.

## Configuration
- `STD_FP_DIV_SAT_EN` defined:
  - On overflow or divide-by-zero, the quotient clamps toward the true sign.
  - SIGNED=0 clamps to 2^WIDTH−1.
  - SIGNED=1 clamps to 2^(WIDTH-1)−1 for a positive result and −2^(WIDTH-1) for a negative one.
  - For divide-by-zero, the sign is taken from the dividend.
- Not defined: wrapping as described under Operation; divide-by-zero quotient is all-ones.
- Flags behave identically in both builds.

## Test plan
All scenarios use WIDTH=8, FRAC_WIDTH=4.
- Unsigned, SIGNED=0: `left`=0x30 (3.0), `right`=0x20 (2.0) -> `out_quotient`=0x18 (1.5), `out_remainder`=0x00, flags 0, `done` exactly 14 cycles after the accepting edge.
- Unsigned remainder, SIGNED=0: 0x10 / 0x30 -> quotient 0x05, remainder 0x10. Then, with SIGNED=1, 0xF0 (−1.0) / 0x30 -> quotient 0xFB, remainder 0xF0.
- Signed, SIGNED=1: 0xD0 (−3.0) / 0x20 -> quotient 0xE8 (−1.5). Then 0x80 / 0xF0 (−1.0) -> `overflow`=1; quotient 0x80 without the macro, 0x7F with it.
- Overflow and zero, SIGNED=0:
  - 0xF0 / 0x01 -> `overflow`=1; quotient 0x00 without the macro, 0xFF with it.
  - 0x25 / 0x00 -> `div_zero`=1, remainder 0x00, `done` after 2 cycles; quotient 0xFF in both builds.
- Back-to-back and ignore:
  - `go` held high continuously -> one `done` every 14 cycles with no bubble.
  - A new operand presented during RUN is ignored; it is the operand present in the DONE cycle that gets accepted.
- Reset: assert `reset_n`=0 mid-RUN, off-clock-edge -> outputs zero immediately and `ready`=1. A fresh `go` after release yields a correct result with 14-cycle latency.
